// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with programmable almost-full and
// almost-empty thresholds, a fill-level output, sticky overflow/underflow
// flags and a build-time choice between registered and first-word-fall-through
// read paths.
//
// state      | meaning
// -----------+----------------------------------------------------------
// level == 0 | empty: rd_empty=1, reads are refused and flag underflow
// 0<level<D  | partial: reads and writes both accepted
// level == D | full: wr_full=1, writes are dropped and flag overflow
//
// The occupancy counter is the only control state; every status flag is a
// registered decode of the next-state level, so all flags move together with
// level on the same edge.
module sync_fifo_param #(
  parameter int DATA_WIDTH       = 16,
  parameter int DEPTH_WIDTH      = 5,
  parameter int ALMOST_FULL_NUM  = 28,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter bit FWFT             = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   level,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int DEPTH = 2 ** DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] LVL_FULL = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] LVL_AF   = (DEPTH_WIDTH + 1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] LVL_AE   = (DEPTH_WIDTH + 1)'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH:0]   level_next;
  logic                   wr_accept;
  logic                   rd_accept;

  // Accepts are qualified by the registered flags, so a write while full is
  // dropped even when a read frees a slot in the same cycle (and vice versa).
  assign wr_accept = wr_en & ~wr_full;
  assign rd_accept = rd_en & ~rd_empty;

  // Next occupancy: +1 write only, -1 read only, hold otherwise.
  always_comb begin
    level_next = level;
    case ({wr_accept, rd_accept})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Storage array; deliberately not reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Level and registered status flags decoded from the next-state level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level        <= '0;
      wr_full      <= 1'b0;
      almost_full  <= 1'b0;
      rd_empty     <= 1'b1;
      almost_empty <= 1'b1;
    end else begin
      level        <= level_next;
      wr_full      <= (level_next == LVL_FULL);
      almost_full  <= (level_next >= LVL_AF);
      rd_empty     <= (level_next == '0);
      almost_empty <= (level_next <= LVL_AE);
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & wr_full)  | (overflow  & ~clr_err);
      underflow <= (rd_en & rd_empty) | (underflow & ~clr_err);
    end
  end

  generate
    if (FWFT == 1'b0) begin : g_std_read
      // Registered read: word appears the cycle after an accepted rd_en and
      // rd_data holds between reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_accept;
          if (rd_accept) begin
            rd_data <= mem[rd_ptr];
          end
        end
      end
    end else begin : g_fwft_read
      // Head word is always presented; forced to zero while empty so the
      // output is defined out of reset even though the array is not.
      assign rd_data  = rd_empty ? '0 : mem[rd_ptr];
      assign rd_valid = ~rd_empty;
    end
  endgenerate

  // Structural sanity on the occupancy counter.
  a_level_range : assert property (@(posedge clk) disable iff (rst)
    level <= LVL_FULL);
  a_full_empty_excl : assert property (@(posedge clk) disable iff (rst)
    !(wr_full && rd_empty));

endmodule
